// File: rtl/retire_trace_pkg.sv
// Shared record type, status codes and the field-by-field retirement comparator
// used by the lockstep trace checker.
package retire_trace_pkg;

    localparam int RT_XLEN = 32;

    typedef enum logic [1:0] {
        STS_IDLE = 2'd0,
        STS_RUN  = 2'd1,
        STS_DONE = 2'd2,
        STS_FAIL = 2'd3
    } sts_e;

    typedef struct packed {
        logic [RT_XLEN-1:0] adr;
        logic [RT_XLEN-1:0] ins;
        logic               wen;
        logic [4:0]         idx;
        logic [RT_XLEN-1:0] wdt;
        logic               lsu;
        logic               lwe;
        logic [RT_XLEN-1:0] lad;
        logic [1:0]         siz;
        logic [RT_XLEN-1:0] sdt;
    } retire_t;

    function automatic logic [RT_XLEN-1:0] size_mask(input logic [1:0] siz);
        logic [RT_XLEN-1:0] m;
        case (siz)
            2'd0:    m = 32'h0000_00FF;
            2'd1:    m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    // Mask bits: [4] sdt, [3] lad, [2] wdt, [1] idx, [0] ins/adr.
    function automatic logic [4:0] retire_cmp(input retire_t exp_r, input retire_t dut_r);
        logic [4:0] m;
        logic       exp_wb;
        logic       dut_wb;
        m      = '0;
        exp_wb = exp_r.wen & (exp_r.idx != 5'd0);
        dut_wb = dut_r.wen & (dut_r.idx != 5'd0);
        m[0]   = (exp_r.adr != dut_r.adr) | (exp_r.ins != dut_r.ins);
        m[1]   = (exp_wb != dut_wb) | (exp_wb & dut_wb & (exp_r.idx != dut_r.idx));
        m[2]   = exp_wb & dut_wb & (exp_r.wdt != dut_r.wdt);
        m[3]   = (exp_r.lsu != dut_r.lsu) | (exp_r.lsu & dut_r.lsu & (exp_r.lad != dut_r.lad));
        // Size/direction only carry meaning when at least one side touched memory.
        if (exp_r.lsu | dut_r.lsu) begin
            if ((exp_r.siz != dut_r.siz) || (exp_r.lwe != dut_r.lwe) ||
                (exp_r.siz == 2'd3) || (dut_r.siz == 2'd3)) begin
                m[4] = 1'b1;
            end else if (exp_r.lsu & exp_r.lwe & dut_r.lsu & dut_r.lwe) begin
                m[4] = ((exp_r.sdt ^ dut_r.sdt) & size_mask(exp_r.siz)) != '0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// Retirement FIFO with combinational head; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate count.
module retire_fifo
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  retire_t push_data,
    input  logic    pop,
    output retire_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    retire_t     mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/retire_trace_checker.sv
// Lockstep checker: buffers live core retirements and compares them in order
// against a streamed expected log, reporting counts, first mismatch and status.
module retire_trace_checker
    import retire_trace_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 8,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            dut_vld,
    input  logic [XLEN-1:0] dut_adr,
    input  logic [XLEN-1:0] dut_ins,
    input  logic            dut_wen,
    input  logic [4:0]      dut_idx,
    input  logic [XLEN-1:0] dut_wdt,
    input  logic            dut_lsu,
    input  logic            dut_lwe,
    input  logic [XLEN-1:0] dut_lad,
    input  logic [1:0]      dut_siz,
    input  logic [XLEN-1:0] dut_sdt,
    input  logic            exp_vld,
    input  logic [XLEN-1:0] exp_adr,
    input  logic [XLEN-1:0] exp_ins,
    input  logic            exp_wen,
    input  logic [4:0]      exp_idx,
    input  logic [XLEN-1:0] exp_wdt,
    input  logic            exp_lsu,
    input  logic            exp_lwe,
    input  logic [XLEN-1:0] exp_lad,
    input  logic [1:0]      exp_siz,
    input  logic [XLEN-1:0] exp_sdt,
    input  logic            exp_lst,
    output logic            exp_rdy,
    output logic [1:0]      sts,
    output logic [31:0]     cnt_ret,
    output logic [31:0]     cnt_err,
    output logic [XLEN-1:0] err_adr,
    output logic [4:0]      err_fld,
    output logic            ovf
);

    sts_e            state_q;
    sts_e            state_d;
    logic [31:0]     cnt_ret_q;
    logic [31:0]     cnt_ret_d;
    logic [31:0]     cnt_err_q;
    logic [31:0]     cnt_err_d;
    logic [XLEN-1:0] err_adr_q;
    logic [XLEN-1:0] err_adr_d;
    logic [4:0]      err_fld_q;
    logic [4:0]      err_fld_d;
    logic            ovf_q;
    logic            ovf_d;

    retire_t dut_rec;
    retire_t exp_rec;
    retire_t head_rec;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    run;
    logic    cmp_fire;
    logic    overflow;
    logic    mismatch;
    logic [4:0] fld_mask;

    always_comb begin
        dut_rec     = '0;
        dut_rec.adr = dut_adr;
        dut_rec.ins = dut_ins;
        dut_rec.wen = dut_wen;
        dut_rec.idx = dut_idx;
        dut_rec.wdt = dut_wdt;
        dut_rec.lsu = dut_lsu;
        dut_rec.lwe = dut_lwe;
        dut_rec.lad = dut_lad;
        dut_rec.siz = dut_siz;
        dut_rec.sdt = dut_sdt;
        exp_rec     = '0;
        exp_rec.adr = exp_adr;
        exp_rec.ins = exp_ins;
        exp_rec.wen = exp_wen;
        exp_rec.idx = exp_idx;
        exp_rec.wdt = exp_wdt;
        exp_rec.lsu = exp_lsu;
        exp_rec.lwe = exp_lwe;
        exp_rec.lad = exp_lad;
        exp_rec.siz = exp_siz;
        exp_rec.sdt = exp_sdt;
    end

    // A full FIFO still accepts a push when the compare frees a slot this cycle.
    assign run       = (state_q == STS_RUN);
    assign cmp_fire  = run && !fifo_empty && exp_vld;
    assign overflow  = run && dut_vld && fifo_full && !cmp_fire;
    assign fifo_push = run && dut_vld && !overflow;
    assign fld_mask  = retire_cmp(exp_rec, head_rec);
    assign mismatch  = (fld_mask != 5'd0);

    retire_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(dut_rec),
        .pop      (cmp_fire),
        .head     (head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STS_IDLE: begin
                if (ena) state_d = STS_RUN;
            end
            STS_RUN: begin
                if (overflow) begin
                    state_d = STS_FAIL;
                end else if (cmp_fire) begin
                    if (mismatch && STOP_ON_ERR) state_d = STS_FAIL;
                    else if (exp_lst)            state_d = STS_DONE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_ret_d = cnt_ret_q;
        cnt_err_d = cnt_err_q;
        err_adr_d = err_adr_q;
        err_fld_d = err_fld_q;
        ovf_d     = ovf_q | overflow;
        if (cmp_fire && (cnt_ret_q != 32'hFFFF_FFFF)) begin
            cnt_ret_d = cnt_ret_q + 32'd1;
        end
        if (cmp_fire && mismatch) begin
            if (cnt_err_q != 32'hFFFF_FFFF) cnt_err_d = cnt_err_q + 32'd1;
            if (cnt_err_q == 32'd0) begin
                err_adr_d = exp_adr;
                err_fld_d = fld_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= STS_IDLE;
            cnt_ret_q <= '0;
            cnt_err_q <= '0;
            err_adr_q <= '0;
            err_fld_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_ret_q <= cnt_ret_d;
            cnt_err_q <= cnt_err_d;
            err_adr_q <= err_adr_d;
            err_fld_q <= err_fld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign exp_rdy = cmp_fire;
    assign sts     = state_q;
    assign cnt_ret = cnt_ret_q;
    assign cnt_err = cnt_err_q;
    assign err_adr = err_adr_q;
    assign err_fld = err_fld_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// Scoreboard bench: two checker instances (stop-on-error and keep-going) share the
// stimulus buses; only the instance with ena raised consumes a given scenario.
`timescale 1ns/1ps
module tb_retire_trace_checker;
    import retire_trace_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  mask;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ena_a, ena_b;
    logic        dut_vld, dut_wen, dut_lsu, dut_lwe;
    logic [31:0] dut_adr, dut_ins, dut_wdt, dut_lad, dut_sdt;
    logic [4:0]  dut_idx;
    logic [1:0]  dut_siz;
    logic        exp_vld, exp_wen, exp_lsu, exp_lwe, exp_lst;
    logic [31:0] exp_adr, exp_ins, exp_wdt, exp_lad, exp_sdt;
    logic [4:0]  exp_idx;
    logic [1:0]  exp_siz;

    logic        rdy_a, rdy_b, ovf_a, ovf_b;
    logic [1:0]  sts_a, sts_b;
    logic [31:0] ret_a, ret_b, err_a, err_b, eadr_a, eadr_b;
    logic [4:0]  fld_a, fld_b;

    int          sel;
    logic        rdy_s, ovf_s;
    logic [1:0]  sts_s;
    logic [31:0] ret_s, err_s, eadr_s;
    logic [4:0]  fld_s;
    assign rdy_s  = (sel == 1) ? rdy_b  : rdy_a;
    assign ovf_s  = (sel == 1) ? ovf_b  : ovf_a;
    assign sts_s  = (sel == 1) ? sts_b  : sts_a;
    assign ret_s  = (sel == 1) ? ret_b  : ret_a;
    assign err_s  = (sel == 1) ? err_b  : err_a;
    assign eadr_s = (sel == 1) ? eadr_b : eadr_a;
    assign fld_s  = (sel == 1) ? fld_b  : fld_a;

    retire_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .rst(rst), .ena(ena_a),
        .dut_vld(dut_vld), .dut_adr(dut_adr), .dut_ins(dut_ins), .dut_wen(dut_wen),
        .dut_idx(dut_idx), .dut_wdt(dut_wdt), .dut_lsu(dut_lsu), .dut_lwe(dut_lwe),
        .dut_lad(dut_lad), .dut_siz(dut_siz), .dut_sdt(dut_sdt),
        .exp_vld(exp_vld), .exp_adr(exp_adr), .exp_ins(exp_ins), .exp_wen(exp_wen),
        .exp_idx(exp_idx), .exp_wdt(exp_wdt), .exp_lsu(exp_lsu), .exp_lwe(exp_lwe),
        .exp_lad(exp_lad), .exp_siz(exp_siz), .exp_sdt(exp_sdt), .exp_lst(exp_lst),
        .exp_rdy(rdy_a), .sts(sts_a), .cnt_ret(ret_a), .cnt_err(err_a),
        .err_adr(eadr_a), .err_fld(fld_a), .ovf(ovf_a)
    );

    retire_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .STOP_ON_ERR(1'b0)) u_cont (
        .clk(clk), .rst(rst), .ena(ena_b),
        .dut_vld(dut_vld), .dut_adr(dut_adr), .dut_ins(dut_ins), .dut_wen(dut_wen),
        .dut_idx(dut_idx), .dut_wdt(dut_wdt), .dut_lsu(dut_lsu), .dut_lwe(dut_lwe),
        .dut_lad(dut_lad), .dut_siz(dut_siz), .dut_sdt(dut_sdt),
        .exp_vld(exp_vld), .exp_adr(exp_adr), .exp_ins(exp_ins), .exp_wen(exp_wen),
        .exp_idx(exp_idx), .exp_wdt(exp_wdt), .exp_lsu(exp_lsu), .exp_lwe(exp_lwe),
        .exp_lad(exp_lad), .exp_siz(exp_siz), .exp_sdt(exp_sdt), .exp_lst(exp_lst),
        .exp_rdy(rdy_b), .sts(sts_b), .cnt_ret(ret_b), .cnt_err(err_b),
        .err_adr(eadr_b), .err_fld(fld_b), .ovf(ovf_b)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_fired;
    bit          mon_en = 1'b0;
    logic [31:0] mon_ret, mon_err, mon_adr;
    logic [4:0]  mon_fld;
    sb_t         sb_q[$];
    retire_t     se[$];
    retire_t     sd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired, got none expected event", name);
    endtask

    // Reference comparison built from normalised views of each record.
    function automatic logic [4:0] model_mask(input retire_t e, input retire_t d);
        logic [4:0]      m;
        int              e_rd, d_rd, w;
        longint          e_mem, d_mem;
        longint unsigned es, ds, modv;
        m     = '0;
        e_rd  = (e.wen && e.idx != 0) ? int'(e.idx) : -1;
        d_rd  = (d.wen && d.idx != 0) ? int'(d.idx) : -1;
        e_mem = e.lsu ? longint'({1'b0, e.lad}) : -1;
        d_mem = d.lsu ? longint'({1'b0, d.lad}) : -1;
        if (e.adr != d.adr || e.ins != d.ins) m[0] = 1'b1;
        if (e_rd != d_rd) m[1] = 1'b1;
        if (e_rd >= 0 && d_rd >= 0 && e.wdt != d.wdt) m[2] = 1'b1;
        if (e_mem != d_mem) m[3] = 1'b1;
        if (e.lsu || d.lsu) begin
            if (e.siz == 2'd3 || d.siz == 2'd3 || e.siz != d.siz || e.lwe != d.lwe) begin
                m[4] = 1'b1;
            end else if (e.lsu && e.lwe && d.lsu && d.lwe) begin
                w    = 8 * (1 << int'(e.siz));
                modv = 64'd1 << w;
                es   = e.sdt;
                ds   = d.sdt;
                if ((es % modv) != (ds % modv)) m[4] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic retire_t mk(input logic [31:0] adr, input logic [31:0] ins,
                                   input logic wen, input logic [4:0] idx, input logic [31:0] wdt,
                                   input logic lsu, input logic lwe, input logic [31:0] lad,
                                   input logic [1:0] siz, input logic [31:0] sdt);
        retire_t r;
        r.adr = adr; r.ins = ins; r.wen = wen; r.idx = idx; r.wdt = wdt;
        r.lsu = lsu; r.lwe = lwe; r.lad = lad; r.siz = siz; r.sdt = sdt;
        return r;
    endfunction

    task automatic gen_pair(input int i, input bit corrupt, output retire_t e, output retire_t d);
        int kind;
        e     = '0;
        e.adr = 32'h8000_0000 + 32'(i) * 32'd4;
        e.ins = $urandom;
        e.idx = 5'($urandom_range(0, 31));
        e.siz = 2'($urandom_range(0, 2));
        e.wdt = $urandom;
        e.lad = $urandom;
        e.sdt = $urandom;
        kind  = $urandom_range(0, 2);
        case (kind)
            0:       e.wen = 1'b1;
            1:       begin e.lsu = 1'b1; e.lwe = 1'b1; end
            default: begin e.wen = 1'b1; e.lsu = 1'b1; end
        endcase
        d = e;
        // Scramble every field the comparison is supposed to ignore.
        if (e.wen && e.idx == 0) d.wen = 1'($urandom_range(0, 1));
        if (!(e.wen && e.idx != 0)) d.wdt = $urandom;
        if (!e.wen) d.idx = 5'($urandom_range(0, 31));
        if (!e.lsu) d.lad = $urandom;
        if (e.lsu && e.lwe) d.sdt = e.sdt ^ (32'($urandom) << (8 << e.siz));
        else                d.sdt = $urandom;
        if (corrupt) begin
            case ($urandom_range(0, 7))
                0: d.adr = d.adr ^ (32'd1 << $urandom_range(0, 31));
                1: d.ins = d.ins ^ (32'd1 << $urandom_range(0, 31));
                2: d.wdt = d.wdt ^ (32'd1 << $urandom_range(0, 31));
                3: d.idx = d.idx ^ (5'd1 << $urandom_range(0, 4));
                4: d.lad = d.lad ^ (32'd1 << $urandom_range(0, 31));
                5: d.sdt = d.sdt ^ (32'd1 << $urandom_range(0, 31));
                6: d.siz = d.siz + 2'd1;
                default: d.lsu = ~d.lsu;
            endcase
        end
    endtask

    task automatic build_random(input int n, input int corrupt_pct);
        retire_t e, d;
        se.delete();
        sd.delete();
        for (int i = 0; i < n; i++) begin
            gen_pair(i, ($urandom_range(0, 99) < corrupt_pct), e, d);
            se.push_back(e);
            sd.push_back(d);
        end
    endtask

    task automatic set_dut(input retire_t r, input logic v);
        dut_vld = v; dut_adr = r.adr; dut_ins = r.ins; dut_wen = r.wen; dut_idx = r.idx;
        dut_wdt = r.wdt; dut_lsu = r.lsu; dut_lwe = r.lwe; dut_lad = r.lad;
        dut_siz = r.siz; dut_sdt = r.sdt;
    endtask

    task automatic set_exp(input retire_t r, input logic v, input logic lst);
        exp_vld = v; exp_adr = r.adr; exp_ins = r.ins; exp_wen = r.wen; exp_idx = r.idx;
        exp_wdt = r.wdt; exp_lsu = r.lsu; exp_lwe = r.lwe; exp_lad = r.lad;
        exp_siz = r.siz; exp_sdt = r.sdt; exp_lst = lst;
    endtask

    task automatic do_reset();
        set_dut('0, 1'b0);
        set_exp('0, 1'b0, 1'b0);
        ena_a = 1'b0;
        ena_b = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_dut(input bit hold);
        int sent  = 0;
        int guard = 0;
        while (sent < se.size()) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin fail_now("dut_drive_timeout"); break; end
            if (sts_s == STS_DONE || sts_s == STS_FAIL) break;
            if (!hold && ($urandom_range(0, 2) == 0 || (sent - exp_fired) >= DEPTH)) begin
                dut_vld = 1'b0;
            end else begin
                set_dut(sd[sent], 1'b1);
                sent++;
            end
        end
        @(negedge clk);
        dut_vld = 1'b0;
    endtask

    task automatic drive_exp(input bit hold);
        int i     = 0;
        int guard = 0;
        while (i < se.size()) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin fail_now("exp_drive_timeout"); break; end
            if (sts_s == STS_DONE || sts_s == STS_FAIL) break;
            if (!hold && $urandom_range(0, 3) == 0) exp_vld = 1'b0;
            else set_exp(se[i], 1'b1, (i == se.size() - 1));
            #4;
            if (exp_vld && rdy_s) begin
                i++;
                exp_fired++;
            end
        end
        @(negedge clk);
        exp_vld = 1'b0;
    endtask

    // inst 0: stop-on-error checker, inst 1: keep-going checker.
    task automatic run_scn(input int inst, input bit hold);
        int          n, fires, errs;
        logic [31:0] f_adr;
        logic [4:0]  f_fld, m;
        logic [1:0]  f_sts;
        bit          f_ovf, stop;
        n     = se.size();
        stop  = (inst == 0);
        fires = 0; errs = 0; f_adr = '0; f_fld = '0;
        f_ovf = hold && (n > DEPTH);
        f_sts = STS_FAIL;
        for (int i = 0; i < n; i++) begin
            m = model_mask(se[i], sd[i]);
            sb_q.push_back('{pc: se[i].adr, mask: m});
        end
        if (!f_ovf) begin
            for (int i = 0; i < n; i++) begin
                m = model_mask(se[i], sd[i]);
                fires++;
                if (m != 0) begin
                    if (errs == 0) begin f_adr = se[i].adr; f_fld = m; end
                    errs++;
                end
                if (m != 0 && stop) begin f_sts = STS_FAIL; break; end
                if (i == n - 1) begin f_sts = STS_DONE; break; end
            end
        end
        do_reset();
        sel       = inst;
        exp_fired = 0;
        mon_ret = '0; mon_err = '0; mon_adr = '0; mon_fld = '0;
        mon_en  = 1'b1;
        ena_a   = (inst == 0);
        ena_b   = (inst == 1);
        @(negedge clk);
        chk("sts_run", sts_s, STS_RUN);
        if (hold) begin
            drive_dut(1'b1);
            repeat (2) @(negedge clk);
            chk("ovf_after_burst", ovf_s, f_ovf);
            chk("sts_after_burst", sts_s, f_ovf ? STS_FAIL : STS_RUN);
            if (!f_ovf) drive_exp(1'b1);
        end else begin
            fork
                drive_dut(1'b0);
                drive_exp(1'b0);
            join
        end
        repeat (3) @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("final_sts", sts_s, f_sts);
        chk("final_cnt_ret", ret_s, fires);
        chk("final_cnt_err", err_s, errs);
        chk("final_err_adr", eadr_s, f_adr);
        chk("final_err_fld", fld_s, f_fld);
        chk("final_ovf", ovf_s, f_ovf);
        chk("unconsumed", sb_q.size(), n - fires);
        sb_q.delete();
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && rdy_s) begin
                if (sb_q.size() == 0) begin
                    fail_now("scoreboard_empty");
                end else begin
                    e = sb_q.pop_front();
                    @(posedge clk);
                    #1;
                    if (mon_ret != 32'hFFFF_FFFF) mon_ret++;
                    if (e.mask != 0) begin
                        if (mon_err == 0) begin mon_adr = e.pc; mon_fld = e.mask; end
                        mon_err++;
                    end
                    chk("cnt_ret", ret_s, mon_ret);
                    chk("cnt_err", err_s, mon_err);
                    chk("err_adr", eadr_s, mon_adr);
                    chk("err_fld", fld_s, mon_fld);
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        retire_t addi5, addi6e, addi6d, sh, lw, sbm_e, sbm_d, sw_e, sw_d, x0_e, x0_d, tmp;
        sel = 0;
        rst = 1'b1;
        set_dut('0, 1'b0);
        set_exp('0, 1'b0, 1'b0);
        ena_a = 1'b0;
        ena_b = 1'b0;
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            sel = k;
            #0;
            chk("rst_sts", sts_s, STS_IDLE);
            chk("rst_cnt_ret", ret_s, 0);
            chk("rst_cnt_err", err_s, 0);
            chk("rst_err_adr", eadr_s, 0);
            chk("rst_err_fld", fld_s, 0);
            chk("rst_ovf", ovf_s, 0);
            chk("rst_exp_rdy", rdy_s, 0);
        end

        addi5  = mk(32'h8000_0000, 32'h0050_0093, 1'b1, 5'd1, 32'h5, 1'b0, 1'b0, 32'h0, 2'd2, 32'h0);
        sh     = mk(32'h8000_0004, 32'h00B5_1823, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h8000_0010, 2'd1, 32'h1234);
        lw     = mk(32'h8000_0008, 32'h0105_2103, 1'b1, 5'd2, 32'h1234, 1'b1, 1'b0, 32'h8000_0010, 2'd2, 32'h0);
        addi6e = mk(32'h8000_0004, 32'h0060_0093, 1'b1, 5'd1, 32'h6, 1'b0, 1'b0, 32'h0, 2'd2, 32'h0);
        addi6d = addi6e;
        addi6d.wdt = 32'h7;

        // Three clean records ending the log.
        se = '{addi5, sh, lw};
        sd = '{addi5, sh, lw};
        run_scn(0, 1'b0);

        // Write-back data mismatch on the second record stops the stop-on-error checker.
        se = '{addi5, addi6e, lw};
        sd = '{addi5, addi6d, lw};
        run_scn(0, 1'b0);

        // x0 write-back, byte store with junk upper bits, then a word store that differs.
        x0_e  = mk(32'h8000_0100, 32'h0000_0013, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd2, 32'h0);
        x0_d  = mk(32'h8000_0100, 32'h0000_0013, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 32'h0, 2'd2, 32'h0);
        sbm_e = mk(32'h8000_0104, 32'h00B5_0023, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h8000_0020, 2'd0, 32'h0000_0012);
        sbm_d = sbm_e;
        sbm_d.sdt = 32'hFFFF_FF12;
        sw_e  = sbm_e;
        sw_e.adr = 32'h8000_0108;
        sw_e.siz = 2'd2;
        sw_d  = sw_e;
        sw_d.sdt = 32'hFFFF_FF12;
        se = '{x0_e, sbm_e, sw_e};
        sd = '{x0_d, sbm_d, sw_d};
        run_scn(1, 1'b0);

        // DEPTH+1 retirements with the expected stream held off overflows the FIFO.
        build_random(DEPTH + 1, 0);
        run_scn(0, 1'b1);

        // Exactly DEPTH retirements fit, then drain in order.
        build_random(DEPTH, 0);
        run_scn(0, 1'b1);

        // Keep-going checker, two mismatches out of five.
        build_random(5, 0);
        tmp = sd[1]; tmp.ins = tmp.ins ^ 32'h1; sd[1] = tmp;
        tmp = sd[3]; tmp.ins = tmp.ins ^ 32'h2; sd[3] = tmp;
        run_scn(1, 1'b0);

        for (int s = 0; s < 10; s++) begin
            build_random($urandom_range(4, 16), 25);
            run_scn(s % 2, 1'b0);
        end

        // Reset dropped mid-stream while a compare is being offered.
        do_reset();
        sel   = 1;
        ena_b = 1'b1;
        @(negedge clk);
        set_dut(addi6d, 1'b1);
        @(negedge clk);
        set_dut(lw, 1'b1);
        @(negedge clk);
        dut_vld = 1'b0;
        set_exp(addi6e, 1'b1, 1'b0);
        #4;
        chk("mid_rdy_first", rdy_s, 1);
        @(negedge clk);
        set_exp(lw, 1'b1, 1'b1);
        #2;
        chk("mid_rdy_second", rdy_s, 1);
        chk("mid_cnt_ret", ret_s, 1);
        chk("mid_cnt_err", err_s, 1);
        chk("mid_err_fld", fld_s, 5'b00100);
        rst = 1'b0;
        #1;
        chk("arst_exp_rdy", rdy_s, 0);
        chk("arst_sts", sts_s, STS_IDLE);
        chk("arst_cnt_ret", ret_s, 0);
        chk("arst_cnt_err", err_s, 0);
        chk("arst_err_adr", eadr_s, 0);
        chk("arst_err_fld", fld_s, 0);
        chk("arst_ovf", ovf_s, 0);
        @(negedge clk);
        set_exp('0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
